// File: rtl/seg_seq_detector_pkg.sv
// Shared segment codes, FSM state encodings and sequence-order helper for
// the seven-segment sequence detector and the display-driving logic.
package seg_seq_detector_pkg;

  // Active-low {g,f,e,d,c,b,a} codes, shared with the display-driving FSM
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [3:0] DIGIT_START = 4'd5;

  // Sn = n digits matched; the encoding doubles as the pos output
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  // Next digit expected from state s; fwd = 5,7,9,8,3, otherwise 5,3,8,9,7
  function automatic logic [3:0] expected_digit(input state_t s, input logic fwd);
    logic [3:0] d;
    case (s)
      S1:      d = fwd ? 4'd7 : 4'd3;
      S2:      d = fwd ? 4'd9 : 4'd8;
      S3:      d = fwd ? 4'd8 : 4'd9;
      S4:      d = fwd ? 4'd3 : 4'd7;
      default: d = DIGIT_START;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment to BCD decoder; valid=0 for any
// code outside the ten digit patterns.
module seg7_decode
  import seg_seq_detector_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (seg_in)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_seq_detector_dff.sv
// Parameterised D flip-flop with asynchronous active-high reset to zero.
module seg_seq_detector_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/seg_seq_detector.sv
// Detects the digit sequence 5,7,9,8,3 (or its reverse 5,3,8,9,7) in a
// stream of strobed seven-segment codes, with a saturating match counter.
module seg_seq_detector
  import seg_seq_detector_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             seg_valid,
  input  logic             dir,
  output logic [3:0]       digit,
  output logic [2:0]       pos,
  output logic             match,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt
);

  logic [3:0]       dec_digit;
  logic             dec_valid;
  logic [2:0]       state_bits;
  state_t           state, state_n;
  logic             order_fwd, order_fwd_n;
  logic [3:0]       digit_n;
  logic             match_n, err_n;
  logic [CNT_W-1:0] cnt_n;

  seg7_decode u_decode (
    .seg_in (seg_in),
    .digit  (dec_digit),
    .valid  (dec_valid)
  );

  seg_seq_detector_dff #(.W(3)) u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (state_n),
    .q     (state_bits)
  );

  assign state = state_t'(state_bits);
  assign pos   = state_bits;

  always_comb begin
    state_n     = state;
    order_fwd_n = order_fwd;
    digit_n     = digit;
    match_n     = 1'b0;
    err_n       = 1'b0;
    cnt_n       = match_cnt;
    if (seg_valid) begin
      if (!dec_valid) begin
        err_n   = 1'b1;
        state_n = S0;
      end else begin
        digit_n = dec_digit;
        if (state != S0 && dec_digit == expected_digit(state, order_fwd)) begin
          if (state == S4) begin
            match_n = 1'b1;
            state_n = S0;
            if (match_cnt != {CNT_W{1'b1}}) cnt_n = match_cnt + 1'b1;
          end else begin
            state_n = state_t'(state_bits + 3'd1);
          end
        end else if (state == S0 && dec_digit == DIGIT_START) begin
          state_n     = S1;
          order_fwd_n = dir;
        end else begin
          // A stray 5 is also a fresh start, so it re-latches the order
          err_n = 1'b1;
          if (dec_digit == DIGIT_START) begin
            state_n     = S1;
            order_fwd_n = dir;
          end else begin
            state_n = S0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_fwd <= 1'b1;
      digit     <= 4'd0;
      match     <= 1'b0;
      err       <= 1'b0;
      match_cnt <= '0;
    end else begin
      order_fwd <= order_fwd_n;
      digit     <= digit_n;
      match     <= match_n;
      err       <= err_n;
      match_cnt <= cnt_n;
    end
  end

endmodule

// File: tb/tb_seg_seq_detector.sv
// Directed bench for seg_seq_detector (CNT_W=2 so saturation is reachable).
module tb_seg_seq_detector;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [6:0]       seg_in = 7'b1111111;
  logic             seg_valid = 1'b0;
  logic             dir = 1'b1;
  logic [3:0]       digit;
  logic [2:0]       pos;
  logic             match;
  logic             err;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C8 = 7'b0000000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] CBAD = 7'b1111111;

  seg_seq_detector #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .seg_valid (seg_valid),
    .dir       (dir),
    .digit     (digit),
    .pos       (pos),
    .match     (match),
    .err       (err),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobe; outputs are sampled 1 time unit after the capturing edge
  task automatic step(input string tag, input logic [6:0] code, input logic d,
                      input int exp_pos, input int exp_digit,
                      input logic exp_match, input logic exp_err);
    seg_in    = code;
    dir       = d;
    seg_valid = 1'b1;
    @(posedge clk);
    #1;
    seg_valid = 1'b0;
    check({tag, ".pos"},   32'(pos),   32'(exp_pos));
    check({tag, ".digit"}, 32'(digit), 32'(exp_digit));
    check({tag, ".match"}, 32'(match), 32'(exp_match));
    check({tag, ".err"},   32'(err),   32'(exp_err));
  endtask

  task automatic idle(input string tag, input int exp_pos);
    @(posedge clk);
    #1;
    check({tag, ".pos"},   32'(pos),   32'(exp_pos));
    check({tag, ".match"}, 32'(match), 32'd0);
    check({tag, ".err"},   32'(err),   32'd0);
  endtask

  task automatic run_fwd(input string tag, input int exp_cnt);
    step({tag, "_5"}, C5, 1'b1, 1, 5, 1'b0, 1'b0);
    step({tag, "_7"}, C7, 1'b1, 2, 7, 1'b0, 1'b0);
    step({tag, "_9"}, C9, 1'b1, 3, 9, 1'b0, 1'b0);
    step({tag, "_8"}, C8, 1'b1, 4, 8, 1'b0, 1'b0);
    step({tag, "_3"}, C3, 1'b1, 0, 3, 1'b1, 1'b0);
    check({tag, ".cnt"}, 32'(match_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst.pos", 32'(pos), 32'd0);
    check("rst.digit", 32'(digit), 32'd0);
    check("rst.match", 32'(match), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.cnt", 32'(match_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle("idle0", 0);

    // Forward sequence
    run_fwd("fwd", 1);
    idle("fwd_idle", 0);

    // Reverse: order latched at the 5, dir then held at 1
    step("rev_5", C5, 1'b0, 1, 5, 1'b0, 1'b0);
    step("rev_3", C3, 1'b1, 2, 3, 1'b0, 1'b0);
    step("rev_8", C8, 1'b1, 3, 8, 1'b0, 1'b0);
    idle("rev_hold", 3);
    step("rev_9", C9, 1'b1, 4, 9, 1'b0, 1'b0);
    step("rev_7", C7, 1'b1, 0, 7, 1'b1, 1'b0);
    check("rev.cnt", 32'(match_cnt), 32'd2);

    // Restart on a stray 5
    step("rs_5a", C5, 1'b1, 1, 5, 1'b0, 1'b0);
    step("rs_7a", C7, 1'b1, 2, 7, 1'b0, 1'b0);
    step("rs_5b", C5, 1'b1, 1, 5, 1'b0, 1'b1);
    step("rs_7b", C7, 1'b1, 2, 7, 1'b0, 1'b0);
    step("rs_9",  C9, 1'b1, 3, 9, 1'b0, 1'b0);
    step("rs_8",  C8, 1'b1, 4, 8, 1'b0, 1'b0);
    step("rs_3",  C3, 1'b1, 0, 3, 1'b1, 1'b0);
    check("rs.cnt", 32'(match_cnt), 32'd3);

    // Invalid code keeps digit, then non-5 in S0
    step("inv_5",   C5,   1'b1, 1, 5, 1'b0, 1'b0);
    step("inv_7",   C7,   1'b1, 2, 7, 1'b0, 1'b0);
    step("inv_bad", CBAD, 1'b1, 0, 7, 1'b0, 1'b1);
    step("s0_8",    C8,   1'b1, 0, 8, 1'b0, 1'b1);
    step("wrong_9", C5,   1'b1, 1, 5, 1'b0, 1'b0);
    step("wrong_3", C3,   1'b1, 0, 3, 1'b0, 1'b1);

    // Asynchronous reset mid-sequence
    step("ar_5", C5, 1'b1, 1, 5, 1'b0, 1'b0);
    step("ar_7", C7, 1'b1, 2, 7, 1'b0, 1'b0);
    step("ar_9", C9, 1'b1, 3, 9, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("ar.pos", 32'(pos), 32'd0);
    check("ar.digit", 32'(digit), 32'd0);
    check("ar.cnt", 32'(match_cnt), 32'd0);
    seg_in = C5;
    seg_valid = 1'b1;
    @(posedge clk);
    #1 seg_valid = 1'b0;
    check("ar_strobe.pos", 32'(pos), 32'd0);
    check("ar_strobe.digit", 32'(digit), 32'd0);
    reset = 1'b0;
    idle("ar_rel", 0);

    // Saturation at 3 with CNT_W=2
    run_fwd("sat1", 1);
    run_fwd("sat2", 2);
    run_fwd("sat3", 3);
    run_fwd("sat4", 3);
    run_fwd("sat5", 3);
    idle("end", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // match and err must never coincide
  always @(negedge clk) begin
    if (match && err) begin
      checks++;
      errors++;
      $display("FAIL excl: match=%0b err=%0b required not both", match, err);
    end
  end

endmodule
